// File: rtl/adder_result_accumulator_if.sv
// Handshake bundle between the adder output, the batch accumulator and the result consumer.
interface adder_result_accumulator_if #(
  parameter int WIDTH     = 32,
  parameter int COUNT     = 4,
  parameter int ACC_WIDTH = 34
);
  localparam int CNT_W = $clog2(COUNT) + 1;

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     Sum;
  logic                 Cout;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_acc;
  logic [CNT_W-1:0]     out_beats;
  logic                 out_ovf;

  modport slave (
    input  in_valid, Sum, Cout, flush, out_ready,
    output in_ready, out_valid, out_acc, out_beats, out_ovf
  );

  modport master (
    output in_valid, Sum, Cout, flush, out_ready,
    input  in_ready, out_valid, out_acc, out_beats, out_ovf
  );
endinterface

// File: rtl/adder_result_accumulator.sv
// Sums COUNT {Cout,Sum} adder results (or a flushed partial batch) into one wide total with a sticky overflow flag.
// Result registered one cycle after the closing beat; in_ready low while a total waits; ACC_SATURATE_EN clamps instead of wrapping.
module adder_result_accumulator #(
  parameter int WIDTH     = 32,
  parameter int COUNT     = 4,
  parameter int ACC_WIDTH = 34
) (
  input  logic                        TClk,
  input  logic                        TRst_n,
  adder_result_accumulator_if.slave   bus
);
  localparam int CNT_W = $clog2(COUNT) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

  typedef enum logic {ACCUM, DONE} state_t;

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d, operand;
  logic [ACC_WIDTH:0]   sum_wide;
  logic [WIDTH:0]       result_w;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 xfer, close, carry;

  logic                 out_valid_q;
  logic [ACC_WIDTH-1:0] out_acc_q;
  logic [CNT_W-1:0]     out_beats_q;
  logic                 out_ovf_q;

  assign result_w = {bus.Cout, bus.Sum};
  assign operand  = ACC_WIDTH'(result_w);
  assign sum_wide = {1'b0, acc_q} + {1'b0, operand};
  assign carry    = sum_wide[ACC_WIDTH];

  always_comb begin
    state_d = state_q;
    xfer    = 1'b0;
    close   = 1'b0;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      ACCUM: begin
        xfer = bus.in_valid;
        if (xfer) begin
`ifdef ACC_SATURATE_EN
          // once clamped, the batch total stays pinned at all-ones
          acc_d = (ovf_q || carry) ? '1 : sum_wide[ACC_WIDTH-1:0];
`else
          acc_d = sum_wide[ACC_WIDTH-1:0];
`endif
          cnt_d = cnt_q + 1'b1;
          ovf_d = ovf_q | carry;
        end
        close = (xfer && cnt_q == LAST) || (bus.flush && (cnt_q != '0 || xfer));
        if (close) state_d = DONE;
      end
      DONE: begin
        if (out_valid_q && bus.out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge TClk or negedge TRst_n) begin
    if (!TRst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_beats_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (close) begin
        out_valid_q <= 1'b1;
        out_acc_q   <= acc_d;
        out_beats_q <= cnt_d;
        out_ovf_q   <= ovf_d;
        acc_q       <= '0;
        cnt_q       <= '0;
        ovf_q       <= 1'b0;
      end else begin
        acc_q <= acc_d;
        cnt_q <= cnt_d;
        ovf_q <= ovf_d;
        if (state_q == DONE && out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = out_valid_q;
  assign bus.out_acc   = out_acc_q;
  assign bus.out_beats = out_beats_q;
  assign bus.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_adder_result_accumulator.sv
// Bench for adder_result_accumulator: batch-level reference model checked every cycle plus directed literal checks.
module tb_adder_result_accumulator;
  localparam int WIDTH     = 32;
  localparam int COUNT     = 4;
  localparam int ACC_WIDTH = 34;

  logic test_clk = 1'b0;
  logic rst_n    = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 test_clk = ~test_clk;

  adder_result_accumulator_if #(.WIDTH(WIDTH), .COUNT(COUNT), .ACC_WIDTH(ACC_WIDTH)) bus ();

  adder_result_accumulator #(.WIDTH(WIDTH), .COUNT(COUNT), .ACC_WIDTH(ACC_WIDTH)) dut (
    .TClk   (test_clk),
    .TRst_n (rst_n),
    .bus    (bus)
  );

  // Reference: a batch is a list of results; its total is plain integer arithmetic.
  bit      pend;
  longint  m_sum;
  int      m_beats;
  longint  e_acc;
  int      e_beats;
  bit      e_ovf;

  always @(posedge test_clk or negedge rst_n) begin
    if (!rst_n) begin
      pend = 0; m_sum = 0; m_beats = 0;
      e_acc = 0; e_beats = 0; e_ovf = 0;
    end else if (!pend) begin
      if (bus.in_valid) begin
        m_sum   = m_sum + longint'({bus.Cout, bus.Sum});
        m_beats = m_beats + 1;
      end
      if (m_beats == COUNT || (bus.flush && m_beats > 0)) begin
        e_ovf = (m_sum >= (64'sd1 <<< ACC_WIDTH));
`ifdef ACC_SATURATE_EN
        e_acc = e_ovf ? ((64'sd1 <<< ACC_WIDTH) - 1) : m_sum;
`else
        e_acc = m_sum % (64'sd1 <<< ACC_WIDTH);
`endif
        e_beats = m_beats;
        pend    = 1;
        m_sum   = 0;
        m_beats = 0;
      end
    end else if (bus.out_ready) begin
      pend = 0;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge test_clk) begin
    chk("in_ready",  longint'(bus.in_ready),  longint'(!pend));
    chk("out_valid", longint'(bus.out_valid), longint'(pend));
    chk("out_acc",   longint'(bus.out_acc),   e_acc);
    chk("out_beats", longint'(bus.out_beats), longint'(e_beats));
    chk("out_ovf",   longint'(bus.out_ovf),   longint'(e_ovf));
  end

  task automatic beat(input logic [WIDTH-1:0] s, input logic c, input logic f);
    bus.in_valid = 1'b1; bus.Sum = s; bus.Cout = c; bus.flush = f;
    @(negedge test_clk);
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.Sum = '0; bus.Cout = 1'b0;
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    @(negedge test_clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.Sum = '0; bus.Cout = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(negedge test_clk);
    rst_n = 1'b1;
    @(negedge test_clk);
    chk("rst in_ready", longint'(bus.in_ready), 1);
    chk("rst out_acc",  longint'(bus.out_acc),  0);

    // 1+2+3+4
    for (int i = 1; i <= 4; i++) beat(WIDTH'(i), 1'b0, 1'b0);
    chk("b4 out_valid", longint'(bus.out_valid), 1);
    chk("b4 out_acc",   longint'(bus.out_acc),   10);
    chk("b4 out_beats", longint'(bus.out_beats), 4);
    chk("b4 out_ovf",   longint'(bus.out_ovf),   0);
    // stalled consumer: upstream offers data that must not be taken
    bus.in_valid = 1'b1; bus.Sum = 32'd99;
    repeat (5) begin
      @(negedge test_clk);
      chk("hold in_ready", longint'(bus.in_ready), 0);
      chk("hold out_acc",  longint'(bus.out_acc),  10);
    end
    bus.in_valid = 1'b0; bus.Sum = '0;
    take();
    chk("hs out_valid", longint'(bus.out_valid), 0);
    chk("hs in_ready",  longint'(bus.in_ready),  1);

    // overflow batch
    for (int i = 0; i < 4; i++) beat(32'hFFFF_FFFF, 1'b1, 1'b0);
    chk("ovf out_ovf", longint'(bus.out_ovf), 1);
`ifdef ACC_SATURATE_EN
    chk("ovf out_acc", longint'(bus.out_acc), 64'h3_FFFF_FFFF);
`else
    chk("ovf out_acc", longint'(bus.out_acc), 64'h3_FFFF_FFFC);
`endif
    take();

    // partial batch closed by a standalone flush
    beat(32'd5, 1'b0, 1'b0);
    beat(32'd7, 1'b0, 1'b0);
    bus.flush = 1'b1;
    @(negedge test_clk);
    bus.flush = 1'b0;
    chk("fl out_acc",   longint'(bus.out_acc),   12);
    chk("fl out_beats", longint'(bus.out_beats), 2);
    take();
    bus.flush = 1'b1;
    @(negedge test_clk);
    bus.flush = 1'b0;
    chk("empty flush out_valid", longint'(bus.out_valid), 0);
    chk("empty flush out_acc",   longint'(bus.out_acc),   12);

    // flush coinciding with the final beat closes once
    for (int i = 0; i < 3; i++) beat(32'd1, 1'b0, 1'b0);
    beat(32'd1, 1'b0, 1'b1);
    chk("fl+last out_beats", longint'(bus.out_beats), 4);
    take();
    @(negedge test_clk);
    chk("fl+last single", longint'(bus.out_valid), 0);

    // single beat with flush; flush while DONE is dropped
    beat(32'd3, 1'b0, 1'b1);
    chk("fl1 out_acc",   longint'(bus.out_acc),   3);
    chk("fl1 out_beats", longint'(bus.out_beats), 1);
    bus.flush = 1'b1;
    @(negedge test_clk);
    bus.flush = 1'b0;
    take();
    repeat (2) @(negedge test_clk);
    chk("done flush dropped", longint'(bus.out_valid), 0);

    // reset mid-batch, asserted between edges
    beat(32'd9, 1'b0, 1'b0);
    beat(32'd9, 1'b0, 1'b0);
    @(posedge test_clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst out_valid", longint'(bus.out_valid), 0);
    chk("arst out_acc",   longint'(bus.out_acc),   0);
    chk("arst out_ovf",   longint'(bus.out_ovf),   0);
    @(negedge test_clk);
    rst_n = 1'b1;
    @(negedge test_clk);
    for (int i = 0; i < 4; i++) beat(32'd1, 1'b0, 1'b0);
    chk("post rst out_acc",   longint'(bus.out_acc),   4);
    chk("post rst out_beats", longint'(bus.out_beats), 4);
    take();
    repeat (2) @(negedge test_clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/adder_result_accumulator.md
Name: adder_result_accumulator

Overview:
- Downstream stage of the N-bit adder; consumes each {Cout, Sum} result and accumulates a fixed-size batch into a wider register.
- Emits one batch total per COUNT results via valid/ready handshake, with a sticky overflow flag.
- Sits between the adder output and the result consumer; gives the adder datapath multi-operand summation without widening the adder.

Parameters:
- WIDTH, 32, adder operand/sum width; input operand is WIDTH+1 bits ({Cout,Sum}).
- COUNT, 4, adder results per batch (>=1).
- ACC_WIDTH, 34, accumulator/output width (>= WIDTH+1).

Ports:
- TClk  input  1  clock, rising edge.
- TRst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  adder result available.
- in_ready  output  1  block accepts a result this cycle.
- Sum  input  WIDTH  adder sum.
- Cout  input  1  adder carry out.
- flush  input  1  emit partial batch.
- out_valid  output  1  batch result available.
- out_ready  input  1  consumer accepts result.
- out_acc  output  ACC_WIDTH  batch total.
- out_beats  output  clog2(COUNT)+1  results in this batch.
- out_ovf  output  1  accumulator overflowed during batch.

Behaviour:
- Reset (TRst_n low, async): state=ACCUM, acc=0, cnt=0, ovf=0, out_valid=0, out_acc=0, out_beats=0, out_ovf=0. Released synchronously to TClk by upstream.
- Operand = {Cout,Sum} zero-extended to ACC_WIDTH.
- in_ready = (state==ACCUM); combinational from state only, no dependence on in_valid.
- Transfer = in_valid && in_ready.
- ACCUM state:
  - On transfer: acc <= acc + operand, modulo 2^ACC_WIDTH.
  - On transfer: ovf set if the true sum >= 2^ACC_WIDTH; ovf is sticky.
  - On transfer: cnt++.
- Batch close: transfer with cnt==COUNT-1, or flush while (cnt>0 or transfer).
  - Next edge registers out_acc = acc_next, out_beats = cnt_next, out_ovf = ovf_next.
  - out_valid <= 1; state <= DONE.
  - acc, cnt, ovf cleared.
  - Latency: result visible one cycle after the closing beat.
- flush with cnt==0 and no transfer: ignored.
- flush in DONE: ignored; it is not remembered.
- flush together with a final beat (cnt==COUNT-1): a single close, out_beats=COUNT.
- DONE state: in_ready=0; out_acc/out_beats/out_ovf held stable.
  - On out_valid && out_ready: out_valid <= 0, state <= ACCUM.
  - in_ready rises the following cycle. No bypass: minimum one idle cycle between batches.
- out_acc/out_beats/out_ovf keep their last values after handshake until the next close.
- Sum/Cout are sampled only on transfer; they are don't-care otherwise.
- Reset mid-batch or in DONE: partial data lost; all outputs return to reset values.

Optional Feature:
- Macro ACC_SATURATE_EN.
- Defined: on overflow, acc clamps to all-ones (2^ACC_WIDTH-1) and stays clamped for the rest of the batch; ovf still set.
- Undefined: acc wraps modulo 2^ACC_WIDTH; ovf set.

Test Plan:
- Assert TRst_n=0 mid-clock -> out_valid=0, out_acc=0, out_ovf=0 immediately; in_ready=1 after release.
- Four beats Cout=0, Sum=1,2,3,4 -> one cycle after 4th beat: out_valid=1, out_acc=10, out_beats=4, out_ovf=0.
- Four beats Cout=1, Sum=0xFFFFFFFF -> out_ovf=1. Without ACC_SATURATE_EN: out_acc=0x3_FFFFFFFC. With it: out_acc=0x3_FFFFFFFF.
- Batch done, hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_acc stable, no beats consumed. Then out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
- Beats 5,7 then flush=1 -> out_acc=12, out_beats=2. A later flush with cnt=0 produces no out_valid.
- Two beats of 9, then reset pulse, then beats 1,1,1,1 -> out_acc=4, out_beats=4.
